// File: rtl/decode_stage_p_pkg.sv
// Shared decode constants: opcode/funct encodings, ID/EX control word layout
// and the redirect-squash FSM state encoding.
package decode_stage_p_pkg;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_JAL   = 6'h03;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_SLTI  = 6'h0a;
   localparam logic [5:0] OP_ANDI  = 6'h0c;
   localparam logic [5:0] OP_ORI   = 6'h0d;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2b;

   localparam logic [5:0] FN_JR    = 6'h08;
   localparam logic [5:0] FN_ADD   = 6'h20;
   localparam logic [5:0] FN_SUB   = 6'h22;
   localparam logic [5:0] FN_AND   = 6'h24;
   localparam logic [5:0] FN_OR    = 6'h25;
   localparam logic [5:0] FN_SLT   = 6'h2a;

   typedef enum logic [3:0] {
      ALU_NOP = 4'd0,
      ALU_ADD = 4'd1,
      ALU_SUB = 4'd2,
      ALU_AND = 4'd3,
      ALU_OR  = 4'd4,
      ALU_SLT = 4'd5
   } alu_op_e;

   // MSB first: reg_write is bit CTRL_W-1, alu_op occupies the low nibble.
   typedef struct packed {
      logic    reg_write;
      logic    mem_read;
      logic    mem_write;
      logic    mem_to_reg;
      logic    alu_src;
      logic    link;
      alu_op_e alu_op;
   } ctrl_t;

   localparam int CTRL_W = $bits(ctrl_t);

   typedef enum logic {
      ST_RUN    = 1'b0,
      ST_SQUASH = 1'b1
   } state_e;

endpackage

// File: rtl/regfile_bypass.sv
// NREG x XLEN register file with two read ports; a same-cycle write-back to a
// read address is bypassed straight to that read port. Register 0 is hardwired to 0.
module regfile_bypass #(
   parameter  int XLEN = 32,
   parameter  int NREG = 32,
   localparam int AW   = $clog2(NREG)
) (
   input  logic            i_clk,
   input  logic            i_rst_n,
   input  logic            i_we,
   input  logic [AW-1:0]   i_waddr,
   input  logic [XLEN-1:0] i_wdata,
   input  logic [AW-1:0]   i_raddr0,
   input  logic [AW-1:0]   i_raddr1,
   output logic [XLEN-1:0] o_rdata0,
   output logic [XLEN-1:0] o_rdata1
);

   logic [XLEN-1:0] r_regs [NREG];
   logic            w_wr_en;

   assign w_wr_en = i_we && (i_waddr != '0);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
      end else if (w_wr_en) begin
         r_regs[i_waddr] <= i_wdata;
      end
   end

   always_comb begin
      o_rdata0 = r_regs[i_raddr0];
      o_rdata1 = r_regs[i_raddr1];
      if (w_wr_en && (i_waddr == i_raddr0)) o_rdata0 = i_wdata;
      if (w_wr_en && (i_waddr == i_raddr1)) o_rdata1 = i_wdata;
      if (i_raddr0 == '0) o_rdata0 = '0;
      if (i_raddr1 == '0) o_rdata1 = '0;
   end

endmodule

// File: rtl/decode_stage_p.sv
// Pipeline decode stage: register read with WB bypass, branch/jump resolution
// with MEM forwarding, load-use and branch-operand stalls, and the ID/EX register.
module decode_stage_p
   import decode_stage_p_pkg::*;
#(
   parameter  int XLEN               = 32,
   parameter  int NREG               = 32,
   parameter  bit SQUASH_ON_REDIRECT = 1'b1,
   localparam int REG_AW             = $clog2(NREG)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              if_valid,
   input  logic [31:0]       instruction,
   input  logic [XLEN-1:0]   pc_plus,
   input  logic              wb_we,
   input  logic [REG_AW-1:0] wb_addr,
   input  logic [XLEN-1:0]   wb_data,
   input  logic              mem_reg_write,
   input  logic [REG_AW-1:0] mem_rd,
   input  logic [XLEN-1:0]   mem_alu_res,
   input  logic              ex_reg_write,
   input  logic              ex_mem_read,
   input  logic [REG_AW-1:0] ex_rd,
   output logic              stall,
   output logic              redirect,
   output logic [XLEN-1:0]   redirect_pc,
   output logic              id_ex_valid,
   output logic [CTRL_W-1:0] id_ex_ctrl,
   output logic [XLEN-1:0]   id_ex_rs_data,
   output logic [XLEN-1:0]   id_ex_rt_data,
   output logic [XLEN-1:0]   id_ex_imm,
   output logic [REG_AW-1:0] id_ex_rd,
   output logic [XLEN-1:0]   id_ex_link_pc,
   output state_e            dbg_state
);

   logic [5:0]        w_opcode;
   logic [5:0]        w_funct;
   logic [REG_AW-1:0] w_rs;
   logic [REG_AW-1:0] w_rt;
   logic [REG_AW-1:0] w_rd;
   logic [XLEN-1:0]   w_imm;
   logic [XLEN-1:0]   w_rf_rs;
   logic [XLEN-1:0]   w_rf_rt;
   logic [XLEN-1:0]   w_br_a;
   logic [XLEN-1:0]   w_br_b;
   logic [XLEN-1:0]   w_br_tgt;
   logic [XLEN-1:0]   w_jmp_tgt;

   ctrl_t             w_ctrl;
   logic [REG_AW-1:0] w_dst;
   logic              w_uses_rs;
   logic              w_uses_rt;
   logic              w_is_beq;
   logic              w_is_bne;
   logic              w_is_j;
   logic              w_is_jr;

   logic              w_ex_hit_rs;
   logic              w_ex_hit_rt;
   logic              w_br_rs;
   logic              w_br_rt;
   logic              w_load_use;
   logic              w_br_ex_hz;
   logic              w_br_mem_hz;
   logic              w_active;
   logic              w_taken;
   logic              w_issue;

   state_e            r_state;
   state_e            w_state_nxt;
   logic              r_mem_load;
   logic [REG_AW-1:0] r_mem_load_rd;

   logic              r_valid;
   logic [CTRL_W-1:0] r_ctrl;
   logic [XLEN-1:0]   r_rs_data;
   logic [XLEN-1:0]   r_rt_data;
   logic [XLEN-1:0]   r_imm;
   logic [REG_AW-1:0] r_rd;
   logic [XLEN-1:0]   r_link_pc;

   assign w_opcode = instruction[31:26];
   assign w_funct  = instruction[5:0];
   assign w_rs     = REG_AW'(instruction[25:21]);
   assign w_rt     = REG_AW'(instruction[20:16]);
   assign w_rd     = REG_AW'(instruction[15:11]);
   assign w_imm    = {{(XLEN-16){instruction[15]}}, instruction[15:0]};

   regfile_bypass #(
      .XLEN (XLEN),
      .NREG (NREG)
   ) u_regfile (
      .i_clk    (clk),
      .i_rst_n  (reset),
      .i_we     (wb_we),
      .i_waddr  (wb_addr),
      .i_wdata  (wb_data),
      .i_raddr0 (w_rs),
      .i_raddr1 (w_rt),
      .o_rdata0 (w_rf_rs),
      .o_rdata1 (w_rf_rt)
   );

   always_comb begin
      w_ctrl    = '0;
      w_dst     = '0;
      w_uses_rs = 1'b0;
      w_uses_rt = 1'b0;
      w_is_beq  = 1'b0;
      w_is_bne  = 1'b0;
      w_is_j    = 1'b0;
      w_is_jr   = 1'b0;
      case (w_opcode)
         OP_RTYPE: begin
            w_uses_rs = 1'b1;
            if (w_funct == FN_JR) begin
               w_is_jr = 1'b1;
            end else begin
               w_uses_rt = 1'b1;
               w_dst     = w_rd;
               w_ctrl.reg_write = 1'b1;
               case (w_funct)
                  FN_ADD:  w_ctrl.alu_op = ALU_ADD;
                  FN_SUB:  w_ctrl.alu_op = ALU_SUB;
                  FN_AND:  w_ctrl.alu_op = ALU_AND;
                  FN_OR:   w_ctrl.alu_op = ALU_OR;
                  FN_SLT:  w_ctrl.alu_op = ALU_SLT;
                  default: w_ctrl.reg_write = 1'b0;
               endcase
            end
         end
         OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI: begin
            w_uses_rs        = 1'b1;
            w_dst            = w_rt;
            w_ctrl.reg_write = 1'b1;
            w_ctrl.alu_src   = 1'b1;
            case (w_opcode)
               OP_SLTI: w_ctrl.alu_op = ALU_SLT;
               OP_ANDI: w_ctrl.alu_op = ALU_AND;
               OP_ORI:  w_ctrl.alu_op = ALU_OR;
               default: w_ctrl.alu_op = ALU_ADD;
            endcase
         end
         OP_LW: begin
            w_uses_rs         = 1'b1;
            w_dst             = w_rt;
            w_ctrl.reg_write  = 1'b1;
            w_ctrl.mem_read   = 1'b1;
            w_ctrl.mem_to_reg = 1'b1;
            w_ctrl.alu_src    = 1'b1;
            w_ctrl.alu_op     = ALU_ADD;
         end
         OP_SW: begin
            w_uses_rs        = 1'b1;
            w_uses_rt        = 1'b1;
            w_ctrl.mem_write = 1'b1;
            w_ctrl.alu_src   = 1'b1;
            w_ctrl.alu_op    = ALU_ADD;
         end
         OP_BEQ: begin
            w_uses_rs = 1'b1;
            w_uses_rt = 1'b1;
            w_is_beq  = 1'b1;
         end
         OP_BNE: begin
            w_uses_rs = 1'b1;
            w_uses_rt = 1'b1;
            w_is_bne  = 1'b1;
         end
         OP_J: begin
            w_is_j = 1'b1;
         end
         OP_JAL: begin
            w_is_j           = 1'b1;
            w_dst            = REG_AW'(NREG - 1);
            w_ctrl.reg_write = 1'b1;
            w_ctrl.link      = 1'b1;
         end
         default: ;
      endcase
   end

   // Branch comparisons see the MEM-stage ALU result ahead of the RF/WB value.
   assign w_br_a = (mem_reg_write && (mem_rd != '0) && (mem_rd == w_rs)) ? mem_alu_res : w_rf_rs;
   assign w_br_b = (mem_reg_write && (mem_rd != '0) && (mem_rd == w_rt)) ? mem_alu_res : w_rf_rt;

   assign w_br_tgt  = pc_plus + {w_imm[XLEN-3:0], 2'b00};
   assign w_jmp_tgt = {pc_plus[XLEN-1:28], instruction[25:0], 2'b00};

   assign w_ex_hit_rs = (ex_rd != '0) && (ex_rd == w_rs);
   assign w_ex_hit_rt = (ex_rd != '0) && (ex_rd == w_rt);
   assign w_br_rs     = w_is_beq || w_is_bne || w_is_jr;
   assign w_br_rt     = w_is_beq || w_is_bne;

   assign w_load_use  = ex_mem_read &&
                        ((w_uses_rs && w_ex_hit_rs) || (w_uses_rt && w_ex_hit_rt));
   assign w_br_ex_hz  = ex_reg_write &&
                        ((w_br_rs && w_ex_hit_rs) || (w_br_rt && w_ex_hit_rt));
   // A load one stage further on still has only its address in mem_alu_res.
   assign w_br_mem_hz = r_mem_load &&
                        ((w_br_rs && (r_mem_load_rd == w_rs)) ||
                         (w_br_rt && (r_mem_load_rd == w_rt)));

   assign w_active = reset && if_valid && (r_state == ST_RUN);
   assign w_taken  = w_is_j || w_is_jr ||
                     (w_is_beq && (w_br_a == w_br_b)) ||
                     (w_is_bne && (w_br_a != w_br_b));

   assign stall       = w_active && (w_load_use || w_br_ex_hz || w_br_mem_hz);
   assign redirect    = w_active && !stall && w_taken;
   assign redirect_pc = w_is_jr ? w_br_a : (w_is_j ? w_jmp_tgt : w_br_tgt);
   assign w_issue     = w_active && !stall;

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_RUN:    if (redirect && SQUASH_ON_REDIRECT) w_state_nxt = ST_SQUASH;
         ST_SQUASH: w_state_nxt = ST_RUN;
         default:   w_state_nxt = ST_RUN;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state       <= ST_RUN;
         r_mem_load    <= 1'b0;
         r_mem_load_rd <= '0;
      end else begin
         r_state       <= w_state_nxt;
         r_mem_load    <= ex_mem_read && (ex_rd != '0);
         r_mem_load_rd <= ex_rd;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_valid   <= 1'b0;
         r_ctrl    <= '0;
         r_rs_data <= '0;
         r_rt_data <= '0;
         r_imm     <= '0;
         r_rd      <= '0;
         r_link_pc <= '0;
      end else if (w_issue) begin
         r_valid   <= 1'b1;
         r_ctrl    <= w_ctrl;
         r_rs_data <= w_rf_rs;
         r_rt_data <= w_rf_rt;
         r_imm     <= w_imm;
         r_rd      <= w_dst;
         r_link_pc <= pc_plus;
      end else begin
         r_valid   <= 1'b0;
         r_ctrl    <= '0;
         r_rs_data <= '0;
         r_rt_data <= '0;
         r_imm     <= '0;
         r_rd      <= '0;
         r_link_pc <= '0;
      end
   end

   assign id_ex_valid   = r_valid;
   assign id_ex_ctrl    = r_ctrl;
   assign id_ex_rs_data = r_rs_data;
   assign id_ex_rt_data = r_rt_data;
   assign id_ex_imm     = r_imm;
   assign id_ex_rd      = r_rd;
   assign id_ex_link_pc = r_link_pc;
   assign dbg_state     = r_state;

endmodule

// File: doc/decode_stage_p.md
DECODE_STAGE_P -- requirements
Module: decode_stage_p

Interface
REQ-001 Parameter XLEN, default 32: datapath and PC width.
REQ-002 Parameter NREG, default 32: architectural register count; REG_AW = clog2(NREG).
REQ-003 Parameter SQUASH_ON_REDIRECT, default 1: 1 = discard the fetched instruction after a redirect; 0 = execute it as a delay slot.
REQ-004 clk  in  1  sole clock, rising edge.
REQ-005 reset  in  1  asynchronous, active-low.
REQ-006 if_valid, instruction, pc_plus  in  1/32/XLEN  IF/ID bundle; pc_plus = PC+4.
REQ-007 wb_we, wb_addr, wb_data  in  1/REG_AW/XLEN  write-back port.
REQ-008 mem_reg_write, mem_rd, mem_alu_res  in  1/REG_AW/XLEN  MEM-stage forwarding source.
REQ-009 ex_reg_write, ex_mem_read, ex_rd  in  1/1/REG_AW  EX-stage hazard source.
REQ-010 stall  out  1  holds PC and IF/ID.
REQ-011 redirect, redirect_pc  out  1/XLEN  taken branch/jump and its target.
REQ-012 id_ex_valid, id_ex_ctrl, id_ex_rs_data, id_ex_rt_data, id_ex_imm, id_ex_rd, id_ex_link_pc  out  registered ID/EX bundle.

Function
REQ-013 Register file: NREG x XLEN, written on rising clk when wb_we=1 and wb_addr!=0; register 0 reads as 0 at all times.
REQ-014 Read bypass: a read address equal to a same-cycle wb_addr (wb_we=1, non-zero) returns wb_data.
REQ-015 Branch operand priority: MEM forward (mem_reg_write, mem_rd match, non-zero), then RF/WB bypass.
REQ-016 Decoded ops: beq 0x04, bne 0x05, j 0x02, jal 0x03, jr (opcode 0, funct 0x08), plus the existing ALU/load/store set driving id_ex_ctrl.
REQ-017 Branch target = pc_plus + (sign-extended imm << 2), modulo 2^XLEN; jump target = {pc_plus[XLEN-1:28], instr[25:0], 2'b00}; jr target = forwarded rs.
REQ-018 jal writes register NREG-1 with link value pc_plus.
REQ-019 Load-use hazard: ex_mem_read=1, ex_rd!=0, and ex_rd equals a used rs/rt -> stall=1, bubble into ID/EX.
REQ-020 Branch/jr operand hazard: ex_reg_write=1 and ex_rd matches an operand -> stall one cycle.
REQ-021 Branch/jr operand hazard, load in MEM: operand produced by a load now in MEM -> stall one further cycle.
REQ-022 redirect is combinational, asserts only when if_valid=1, stall=0, and FSM=RUN.
REQ-023 FSM states RUN and SQUASH; RUN->SQUASH on redirect when SQUASH_ON_REDIRECT=1; SQUASH->RUN unconditionally after one cycle.
REQ-024 In SQUASH, the incoming instruction is discarded: id_ex_valid=0 next cycle, no hazard or redirect raised.
REQ-025 ID/EX register update: loads the decode result when stall=0 and if_valid=1 and FSM=RUN; otherwise loads a bubble (valid=0, ctrl=0).
REQ-026 Latency: instruction accepted at edge N appears on id_ex_* after edge N+1.
REQ-027 Simultaneous stall and redirect condition: stall wins; redirect=0 that cycle.

Reset
REQ-028 Asserting reset (low) asynchronously clears all ID/EX outputs to 0, sets FSM=RUN and clears all registers to 0.
REQ-029 Combinational outputs stall and redirect are forced to 0 while reset is low.
REQ-030 Reset mid-stall or mid-SQUASH abandons that state; the first instruction after release decodes normally.

Structure
REQ-031 Shared package holds opcode/funct constants, the id_ex_ctrl field layout and CTRL_W, and FSM state encodings.
REQ-032 Single sub-module regfile_bypass (parametrised by XLEN and NREG) holds the register file and the WB bypass; all else is inline.

Verification
REQ-033 Write-read bypass: wb_we=1, wb_addr=5, wb_data=0xDEAD_BEEF with rs=5 in the same cycle -> id_ex_rs_data=0xDEAD_BEEF.
REQ-034 Load-use: lw to r8 in EX, then add reading r8 -> stall=1 for 1 cycle; id_ex_valid=0 for that cycle; add issues next.
REQ-035 MEM forward: beq r3,r4 with mem_rd=3, mem_alu_res=7, RF r4=7 -> redirect=1; redirect_pc = pc_plus + (imm<<2).
REQ-036 Squash: taken j with SQUASH_ON_REDIRECT=1 -> the following fetch yields id_ex_valid=0; with 0 it issues.
REQ-037 Zero register: writing r0 with 0x1234 and then reading r0 -> 0.
REQ-038 Reset: reset low during stall -> stall=0 and id_ex_valid=0 immediately, without waiting for clk.
